seq_detector_param: RTL

//  Parametrised, runtime-programmable serial pattern detector; next generation of the fixed "1011" Moore detector.

---
 rtl/seq_detector_param.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector. It produces a registered one-cycle match pulse.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             detector_out
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    // The fill counter is the real state. The phase only names which side of len it sits on.
    typedef enum logic {FILLING, ARMED} phase_t;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             out_q, out_d;

    logic [PAT_W-1:0] hist_sh;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    phase_t           phase_n;
    logic             hit;
    logic             hit_acc;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
`ifdef SEQ_DET_COUNT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        out_d    = 1'b0;
        hist_sh  = {hist_q[PAT_W-2:0], sequence_in};
        fill_inc = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + LEN_W'(1);
        phase_n  = (fill_inc >= len_q) ? ARMED : FILLING;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        // Matching is evaluated on the post-shift history, so a pulse lands one edge after the last bit.
        hit     = (len_q != '0) && (phase_n == ARMED) && (((hist_sh ^ pat_q) & mask) == '0);
        hit_acc = 1'b0;

        if (cfg_load) begin
            pat_d  = pattern;
            len_d  = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
            ovl_d  = overlap_en;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d  = hist_sh;
            hit_acc = hit;
            out_d   = hit;
            // In non-overlap mode, refilling from zero makes the stale history bits irrelevant.
            fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (hit_acc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
`endif

    assign detector_out = out_q;

endmodule
